matrix_frame_scanner: RTL and testbench



---
 rtl/matrix_frame_scanner.sv | 128 ++++++++++++
 tb/tb_matrix_frame_scanner.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_frame_scanner.sv
// Double-buffered 2x8x8 frame store with a row/panel scanner for the X and Y LED panels.
// Commits queue a bank swap that lands only on the last cycle of the frame.
module matrix_frame_scanner #(
    parameter int unsigned TICK_DIV = 65536,
    parameter int unsigned BLANK    = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_panel,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    input  logic       commit,
    output logic       commit_pending,
    output logic       frame_start,
    output logic [7:0] row,
    output logic [7:0] colx,
    output logic [7:0] coly
);

    localparam int unsigned CW = $clog2(TICK_DIV);

    typedef enum logic {
        IDLE,
        PENDING
    } commit_state_e;

    commit_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    slot_q, slot_d;
    logic          sel_q, sel_d;
    logic [7:0]    mem_q [32];
    logic [7:0]    mem_d [32];
    logic [7:0]    row_q, row_d;
    logic [7:0]    colx_q, colx_d;
    logic [7:0]    coly_q, coly_d;
    logic          fs_q, fs_d;

    logic          slot_end;
    logic          frame_end;
    logic [2:0]    scan_row;
    logic          scan_panel;
    logic [7:0]    front_row;

    assign wr_ready       = (state_q == IDLE);
    assign commit_pending = (state_q == PENDING);
    assign frame_start    = fs_q;
    assign row            = row_q;
    assign colx           = colx_q;
    assign coly           = coly_q;

    always_comb begin
        slot_end   = (cnt_q == CW'(TICK_DIV - 1));
        frame_end  = slot_end && (slot_q == 4'd15);
        cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
        slot_d     = slot_end ? slot_q + 4'd1 : slot_q;
        scan_row   = slot_q[3:1];
        scan_panel = slot_q[0];
        // Memory index is {bank, panel, row}; sel_q names the front bank.
        front_row  = mem_q[{sel_q, scan_panel, scan_row}];
    end

    always_comb begin
        row_d  = '0;
        colx_d = '0;
        coly_d = '0;
        fs_d   = (cnt_q == '0) && (slot_q == 4'd0);
        if (cnt_q >= CW'(BLANK)) begin
            row_d = 8'd1 << scan_row;
            if (scan_panel) begin
                coly_d = front_row;
            end else begin
                colx_d = front_row;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        mem_d   = mem_q;
        if (wr_en && wr_ready) begin
            mem_d[{~sel_q, wr_panel, wr_row}] = wr_data;
        end
        case (state_q)
            IDLE: begin
                if (commit) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (frame_end) begin
                    state_d = IDLE;
                    sel_d   = ~sel_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
            sel_q   <= 1'b0;
            row_q   <= '0;
            colx_q  <= '0;
            coly_q  <= '0;
            fs_q    <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            sel_q   <= sel_d;
            row_q   <= row_d;
            colx_q  <= colx_d;
            coly_q  <= coly_d;
            fs_q    <= fs_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_matrix_frame_scanner.sv
// Scoreboard bench for matrix_frame_scanner: a frame-level reference model predicts every
// output cycle, and a separate monitor pops and compares after each rising edge.
module tb_matrix_frame_scanner;

    localparam int unsigned TD = 8;
    localparam int unsigned BL = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic       wr_panel = 1'b0;
    logic [2:0] wr_row = '0;
    logic [7:0] wr_data = '0;
    logic       commit = 1'b0;
    logic       wr_ready;
    logic       commit_pending;
    logic       frame_start;
    logic [7:0] row;
    logic [7:0] colx;
    logic [7:0] coly;

    matrix_frame_scanner #(.TICK_DIV(TD), .BLANK(BL)) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_panel       (wr_panel),
        .wr_row         (wr_row),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .commit         (commit),
        .commit_pending (commit_pending),
        .frame_start    (frame_start),
        .row            (row),
        .colx           (colx),
        .coly           (coly)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] colx;
        logic [7:0] coly;
        logic       fs;
        logic       rdy;
        logic       pend;
    } obs_t;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;

    // Reference model: panels as [panel][row] arrays, time as cycles since reset release.
    logic [7:0] front_m [2][8];
    logic [7:0] back_m  [2][8];
    bit         pend_m;
    int         n_m;

    function automatic obs_t sample_dut();
        obs_t o;
        o.row  = row;
        o.colx = colx;
        o.coly = coly;
        o.fs   = frame_start;
        o.rdy  = wr_ready;
        o.pend = commit_pending;
        return o;
    endfunction

    task automatic compare(input string name, input obs_t got, input obs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            if (miscompares <= 20)
                $display("FAIL %s n=%0d: got row=%h colx=%h coly=%h fs=%b rdy=%b pend=%b, expected row=%h colx=%h coly=%h fs=%b rdy=%b pend=%b",
                         name, n_m, got.row, got.colx, got.coly, got.fs, got.rdy, got.pend,
                         exp.row, exp.colx, exp.coly, exp.fs, exp.rdy, exp.pend);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < 8; r++) begin
                front_m[p][r] = '0;
                back_m[p][r]  = '0;
            end
        pend_m = 1'b0;
        n_m    = 0;
    endtask

    // One clock of stimulus; predicts what the DUT shows right after the coming edge.
    task automatic step(input logic we, input logic pnl, input logic [2:0] rw,
                        input logic [7:0] d, input logic cm);
        int c, s, r, p;
        obs_t e;
        logic [7:0] t;
        @(negedge clk);
        wr_en = we; wr_panel = pnl; wr_row = rw; wr_data = d; commit = cm;
        c = n_m % TD;
        s = (n_m / TD) % 16;
        r = s / 2;
        p = s % 2;
        e = '0;
        e.fs = (c == 0) && (s == 0);
        if (c >= BL) begin
            e.row  = 8'(1 << r);
            e.colx = (p == 0) ? front_m[0][r] : 8'h00;
            e.coly = (p == 1) ? front_m[1][r] : 8'h00;
        end
        if (we && !pend_m) back_m[pnl][rw] = d;
        if (pend_m && c == TD - 1 && s == 15) begin
            for (int pp = 0; pp < 2; pp++)
                for (int rr = 0; rr < 8; rr++) begin
                    t = front_m[pp][rr];
                    front_m[pp][rr] = back_m[pp][rr];
                    back_m[pp][rr]  = t;
                end
            pend_m = 1'b0;
        end else if (cm && !pend_m) begin
            pend_m = 1'b1;
        end
        e.rdy  = !pend_m;
        e.pend = pend_m;
        exp_q.push_back(e);
        n_m++;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    task automatic idle_until_clear();
        for (int i = 0; i < 300 && pend_m; i++) idle(1);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        mon_en = 1'b1;
    endtask

    // Monitor: every edge while enabled, the DUT presents one output cycle.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    compare("underflow", sample_dut(), ~sample_dut());
                end else begin
                    e = exp_q.pop_front();
                    compare("scan", sample_dut(), e);
                end
            end
        end
    end

    initial begin
        obs_t zero_obs;
        zero_obs = '0;
        zero_obs.rdy = 1'b1;
        model_reset();

        // Held in reset: outputs quiet, writes open.
        #12;
        compare("in_reset_a", sample_dut(), zero_obs);
        @(negedge clk);
        compare("in_reset_b", sample_dut(), zero_obs);
        release_reset();

        idle(TD * 16 + 5);

        // Write X3/Y3, commit, then a dropped write while pending.
        step(1'b1, 1'b0, 3'd3, 8'hA5, 1'b0);
        step(1'b1, 1'b1, 3'd3, 8'h3C, 1'b1);
        idle(3);
        step(1'b1, 1'b0, 3'd0, 8'hFF, 1'b0);
        idle_until_clear();
        idle(TD * 16);

        // Second commit brings back the old (zero) front.
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        idle_until_clear();
        idle(TD * 16);

        // Late commit on the swap cycle while idle.
        for (int i = 0; i < 300 && !((n_m % TD) == TD - 1 && ((n_m / TD) % 16) == 15); i++) idle(1);
        step(1'b1, 1'b1, 3'd5, 8'h81, 1'b1);
        idle(TD * 16 * 2 + 4);

        // Randomized writes and commits.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)), $urandom_range(0, 59) == 0);
        idle_until_clear();

        // Write something visible, commit, then reset while still pending.
        step(1'b1, 1'b0, 3'd0, 8'h5A, 1'b1);
        idle(20);
        @(negedge clk);
        mon_en = 1'b0;
        exp_q.delete();
        #2;
        reset = 1'b0;
        #1;
        compare("async_reset", sample_dut(), zero_obs);
        #10;
        compare("held_reset", sample_dut(), zero_obs);
        release_reset();
        idle(TD * 16 + 8);

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d leftover entries, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
